scancode_decoder: RTL and testbench
===================================

SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 The module SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port scan_code  input  [7:0]  latest received PS/2 Set-2 byte; a level held until the next byte arrives, with no strobe.
REQ-005 Port ascii_code  output  [7:0]  registered ASCII of the currently held printable key; 0x00 when none.

Function
REQ-006 The module SHALL keep a register scan_q; a new byte is detected on any rising edge where scan_code != scan_q and scan_code != 0x00.
REQ-007 On detection, scan_q <= scan_code and all decode state and ascii_code SHALL update on that same edge, giving 1-cycle latency.
REQ-008 Without detection, all state and ascii_code SHALL hold.
REQ-009 Prefix flags SHALL be brk (set by 0xF0) and ext (set by 0xE0); a prefix byte SHALL NOT change ascii_code.
REQ-010 Any non-prefix byte SHALL be consumed and SHALL clear brk and ext on the same edge.
REQ-011 Modifiers SHALL be lshift (0x12) and rshift (0x59); make sets the flag, break clears it, and ascii_code SHALL NOT change; shift = lshift | rshift.
REQ-012 Break (brk=1) of a non-modifier key SHALL set ascii_code to 0x00.
REQ-013 Make (brk=0, ext=0) of a non-modifier key SHALL set ascii_code from the table; unmapped codes SHALL give 0x00.
REQ-014 Letter table: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z; output is uppercase when the upper flag is 1, else lowercase.
REQ-015 Digit table (unshifted/shifted): 45 0/), 16 1/!, 1E 2/@, 26 3/#, 25 4/$, 2E 5/%, 36 6/^, 3D 7/&, 3E 8/*, 46 9/(.
REQ-016 Punctuation table (unshifted/shifted): 4E -/_, 55 =/+, 54 [/{, 5B ]/}, 5D \/|, 4C ;/:, 52 '/", 41 ,/<, 49 ./>, 4A //?, 0E `/~.
REQ-017 Control keys, shift-independent: 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08, 76 -> 0x1B, 0D -> 0x09.
REQ-018 Extended make (ext=1, brk=0): E0 5A -> 0x0D, E0 4A -> 0x2F, any other -> 0x00; an extended break follows REQ-012.
REQ-019 A byte that duplicates scan_q (typematic repeat) SHALL be ignored per REQ-006.

Reset
REQ-020 While rst_n=0: ascii_code=0x00, scan_q=0x00, brk=ext=lshift=rshift=0, caps=0; the effect SHALL be immediate and independent of clk.
REQ-021 Reset asserted mid-sequence (e.g. after 0xF0) SHALL discard pending prefixes.
REQ-022 After reset deassertion, the first non-zero scan_code SHALL be processed on the next rising edge.

Configuration
REQ-023 Macro CAPS_LOCK_EN SHALL control caps-lock support.
REQ-024 With CAPS_LOCK_EN defined: make of 0x58 SHALL toggle caps, its break SHALL be ignored, ascii_code SHALL be unchanged on both, and upper = shift XOR caps for letters only.
REQ-025 Without CAPS_LOCK_EN: no caps register exists, 0x58 is an unmapped key per REQ-012/REQ-013, and upper = shift.

Verification
REQ-026 Bytes 1C, F0, 1C -> ascii_code 0x61 one cycle after 1C, unchanged after F0, 0x00 after the final 1C.
REQ-027 Bytes 12, 1C -> 0x41; then F0, 12 -> holds 0x41; then F0, 1C -> 0x00.
REQ-028 Bytes 59, 16 -> 0x21; then F0, 16 -> 0x00; then F0, 59, 45 -> 0x30.
REQ-029 Bytes E0, 5A -> 0x0D; then E0, 75 -> 0x00; then 5A (non-extended) -> 0x0D with ext cleared.
REQ-030 Bytes 58 then 1C: with CAPS_LOCK_EN -> 0x41; without it -> 0x61. Bytes 58 then 12, 1C with CAPS_LOCK_EN -> 0x61.
REQ-031 Byte 1C -> 0x61, then assert rst_n=0 between edges -> ascii_code 0x00 immediately; bytes F0 then reset then 1C -> 0x61.

Source files
------------

// File: rtl/scancode_decoder.sv
// PS/2 Set-2 scan code to ASCII decoder for a level-held byte input without a strobe.
// Optional caps-lock support is enabled by defining CAPS_LOCK_EN.
module scancode_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  output logic [7:0] ascii_code
);

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
`ifdef CAPS_LOCK_EN
  localparam logic [7:0] SC_CAPS   = 8'h58;
`endif

  logic [7:0] scan_q, scan_d;
  logic [7:0] ascii_q, ascii_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
`ifdef CAPS_LOCK_EN
  logic       caps_q, caps_d;
`endif
  logic       detect;
  logic       shift;
  logic       upper;

  function automatic logic [7:0] map_key(input logic [7:0] code,
                                         input logic       up,
                                         input logic       sh);
    logic [7:0] letter;
    logic [7:0] res;
    letter = 8'h00;
    res    = 8'h00;
    case (code)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    // Letters follow the case flag; digits and punctuation follow shift only.
    case (code)
      8'h45: res = sh ? 8'h29 : 8'h30;
      8'h16: res = sh ? 8'h21 : 8'h31;
      8'h1E: res = sh ? 8'h40 : 8'h32;
      8'h26: res = sh ? 8'h23 : 8'h33;
      8'h25: res = sh ? 8'h24 : 8'h34;
      8'h2E: res = sh ? 8'h25 : 8'h35;
      8'h36: res = sh ? 8'h5E : 8'h36;
      8'h3D: res = sh ? 8'h26 : 8'h37;
      8'h3E: res = sh ? 8'h2A : 8'h38;
      8'h46: res = sh ? 8'h28 : 8'h39;
      8'h4E: res = sh ? 8'h5F : 8'h2D;
      8'h55: res = sh ? 8'h2B : 8'h3D;
      8'h54: res = sh ? 8'h7B : 8'h5B;
      8'h5B: res = sh ? 8'h7D : 8'h5D;
      8'h5D: res = sh ? 8'h7C : 8'h5C;
      8'h4C: res = sh ? 8'h3A : 8'h3B;
      8'h52: res = sh ? 8'h22 : 8'h27;
      8'h41: res = sh ? 8'h3C : 8'h2C;
      8'h49: res = sh ? 8'h3E : 8'h2E;
      8'h4A: res = sh ? 8'h3F : 8'h2F;
      8'h0E: res = sh ? 8'h7E : 8'h60;
      8'h29: res = 8'h20;
      8'h5A: res = 8'h0D;
      8'h66: res = 8'h08;
      8'h76: res = 8'h1B;
      8'h0D: res = 8'h09;
      default: res = 8'h00;
    endcase
    if (letter != 8'h00) begin
      res = up ? (letter - 8'h20) : letter;
    end
    return res;
  endfunction

  assign detect = (scan_code != scan_q) && (scan_code != 8'h00);
  assign shift  = lshift_q | rshift_q;
`ifdef CAPS_LOCK_EN
  assign upper  = shift ^ caps_q;
`else
  assign upper  = shift;
`endif

  always_comb begin
    scan_d   = scan_q;
    ascii_d  = ascii_q;
    brk_d    = brk_q;
    ext_d    = ext_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
`ifdef CAPS_LOCK_EN
    caps_d   = caps_q;
`endif
    if (detect) begin
      scan_d = scan_code;
      if (scan_code == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (scan_code == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (scan_code == SC_LSHIFT) begin
          lshift_d = ~brk_q;
        end else if (scan_code == SC_RSHIFT) begin
          rshift_d = ~brk_q;
`ifdef CAPS_LOCK_EN
        end else if (scan_code == SC_CAPS) begin
          if (!brk_q) caps_d = ~caps_q;
`endif
        end else if (brk_q) begin
          ascii_d = 8'h00;
        end else if (ext_q) begin
          // Only keypad Enter and keypad slash produce output from the E0 page.
          if (scan_code == 8'h5A)      ascii_d = 8'h0D;
          else if (scan_code == 8'h4A) ascii_d = 8'h2F;
          else                         ascii_d = 8'h00;
        end else begin
          ascii_d = map_key(scan_code, upper, shift);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q   <= 8'h00;
      ascii_q  <= 8'h00;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
`ifdef CAPS_LOCK_EN
      caps_q   <= 1'b0;
`endif
    end else begin
      scan_q   <= scan_d;
      ascii_q  <= ascii_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
`ifdef CAPS_LOCK_EN
      caps_q   <= caps_d;
`endif
    end
  end

  assign ascii_code = ascii_q;

endmodule

// File: tb/tb_scancode_decoder.sv
// Scoreboard bench for scancode_decoder: the driver queues expected ASCII per byte,
// a negedge monitor pops and compares when each entry comes due.
module tb_scancode_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] scan_code;
  logic [7:0] ascii_code;

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  scancode_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_code  (scan_code),
    .ascii_code (ascii_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input logic [7:0] act, input logic [7:0] exp, input string nm);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic expect_at(input int due, input logic [7:0] exp, input string nm);
    exp_t e;
    e.due  = due;
    e.exp  = exp;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Present a byte at the negedge; the DUT registers it on the next posedge.
  task automatic send(input logic [7:0] b, input logic [7:0] exp, input string nm);
    @(negedge clk);
    scan_code = b;
    expect_at(cyc + 1, exp, nm);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(ascii_code, e.exp, e.name);
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    scan_code = 8'h00;
    #1;
    check(ascii_code, 8'h00, "reset_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(8'h1C, 8'h61, "a_make");
    send(8'hF0, 8'h61, "brk_prefix_hold");
    send(8'h1C, 8'h00, "a_break");

    send(8'h12, 8'h00, "lshift_make_hold");
    send(8'h1C, 8'h41, "A_shifted");
    send(8'hF0, 8'h41, "brk_hold2");
    send(8'h12, 8'h41, "lshift_break_hold");
    send(8'hF0, 8'h41, "brk_hold3");
    send(8'h1C, 8'h00, "A_break");

    send(8'h59, 8'h00, "rshift_make_hold");
    send(8'h16, 8'h21, "bang");
    send(8'hF0, 8'h21, "brk_hold4");
    send(8'h16, 8'h00, "bang_break");
    send(8'hF0, 8'h00, "brk_hold5");
    send(8'h59, 8'h00, "rshift_break_hold");
    send(8'h45, 8'h30, "zero_unshifted");

    send(8'hE0, 8'h30, "ext_prefix_hold");
    send(8'h5A, 8'h0D, "kp_enter");
    send(8'hE0, 8'h0D, "ext_prefix_hold2");
    send(8'h75, 8'h00, "ext_unmapped");
    send(8'h5A, 8'h0D, "enter_ext_cleared");

    send(8'h12, 8'h0D, "lshift_make_hold2");
    send(8'h4A, 8'h3F, "question");
    send(8'hF0, 8'h3F, "brk_hold6");
    send(8'h12, 8'h3F, "lshift_break_hold2");
    send(8'hE0, 8'h3F, "ext_prefix_hold3");
    send(8'h4A, 8'h2F, "kp_slash");
    send(8'h0D, 8'h09, "tab");
    send(8'h66, 8'h08, "backspace");
    send(8'h29, 8'h20, "space");
    send(8'h52, 8'h27, "apostrophe");
    send(8'h12, 8'h27, "lshift_make_hold3");
    send(8'h52, 8'h22, "dquote");
    send(8'hF0, 8'h22, "brk_hold7");
    send(8'h12, 8'h22, "lshift_break_hold3");
    send(8'h76, 8'h1B, "escape");
    send(8'h00, 8'h1B, "zero_byte_ignored");
    send(8'h76, 8'h1B, "repeat_ignored");
    send(8'h05, 8'h00, "unmapped_make");
    send(8'h4D, 8'h70, "p_make");
    send(8'hE0, 8'h70, "ext_prefix_hold4");
    send(8'hF0, 8'h70, "brk_prefix_hold8");
    send(8'h75, 8'h00, "ext_break");

`ifdef CAPS_LOCK_EN
    send(8'h58, 8'h00, "caps_on_hold");
    send(8'h1C, 8'h41, "A_caps");
    send(8'h12, 8'h41, "lshift_make_hold4");
    send(8'h1C, 8'h61, "a_caps_shift");
    send(8'hF0, 8'h61, "brk_hold9");
    send(8'h12, 8'h61, "lshift_break_hold4");
    send(8'hF0, 8'h61, "brk_hold10");
    send(8'h58, 8'h61, "caps_break_ignored");
    send(8'h16, 8'h31, "digit_caps_unaffected");
    send(8'h58, 8'h31, "caps_off_hold");
    send(8'h1C, 8'h61, "a_caps_off");
`else
    send(8'h58, 8'h00, "k58_unmapped");
    send(8'h1C, 8'h61, "a_nocaps");
    send(8'h12, 8'h61, "lshift_make_hold4");
    send(8'h1C, 8'h41, "A_nocaps_shift");
    send(8'hF0, 8'h41, "brk_hold9");
    send(8'h12, 8'h41, "lshift_break_hold4");
    send(8'hF0, 8'h41, "brk_hold10");
    send(8'h58, 8'h00, "k58_break");
    send(8'h16, 8'h31, "digit_one");
    send(8'h58, 8'h00, "k58_unmapped2");
    send(8'h1C, 8'h61, "a_after_k58");
`endif

    // Asynchronous reset between edges, then the held byte is reprocessed.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check(ascii_code, 8'h00, "async_reset_immediate");
    @(negedge clk);
    rst_n = 1'b1;
    expect_at(cyc + 1, 8'h61, "first_after_reset");

    send(8'hF0, 8'h61, "brk_before_reset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    scan_code = 8'h1C;
    #1 check(ascii_code, 8'h00, "async_reset_midseq");
    @(negedge clk);
    rst_n = 1'b1;
    expect_at(cyc + 1, 8'h61, "prefix_discarded");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
